// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI-lite arbiter.
// Holds the FSM state encoding, the AXI response codes and the master ids
// used by the last-winner register of the round-robin build.
package axi_lite_arbiter_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned RESP_W  = 2;

    // Arbiter FSM: IDLE arbitrates, the other three hold one grant each.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'b00,
        ST_IFU_RD = 2'b01,
        ST_LSU_RD = 2'b10,
        ST_LSU_WR = 2'b11
    } arb_state_e;

    // AXI response codes; the arbiter forwards them untouched.
    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    // Master ids.
    localparam logic MST_IFU = 1'b0;
    localparam logic MST_LSU = 1'b1;

endpackage

// File: rtl/axi_lite_arbiter.sv
// 2-master to 1-slave AXI-lite arbiter: IFU (read only) and LSU (read/write)
// share one memory slave, one transaction at a time.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ifu_ar* / ifu_r*  IFU read address / read response
//   lsu_ar* / lsu_r*  LSU read address / read response
//   lsu_aw* / lsu_w*  LSU write address / write data
//   lsu_b*            LSU write response
//   s_*               slave side of all five channels
//
// Build option:
//   AXI_ARB_ROUND_ROBIN_EN  defined: the master that did not win the last
//                           grant has priority on contention.
//                           undefined: fixed priority LSU write > LSU read >
//                           IFU read.
//
// The grant is registered in IDLE (one cycle of arbitration latency) and held
// until the response handshake; while granted, the master's channels are
// routed combinationally to the slave.
module axi_lite_arbiter
    import axi_lite_arbiter_pkg::*;
#(
    parameter  int unsigned ADDR_W = 32,
    parameter  int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [RESP_W-1:0] ifu_rresp,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,

    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [RESP_W-1:0] lsu_rresp,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    output logic              lsu_awready,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic [RESP_W-1:0] lsu_bresp,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,

    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [RESP_W-1:0] s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [RESP_W-1:0] s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready
);

    arb_state_e state_q, state_d;

    // Per-grant "address/data already accepted" flags.
    logic ar_done_q;
    logic aw_done_q;
    logic w_done_q;

    logic lsu_wr_req;
    logic lsu_any_req;

    assign lsu_wr_req  = lsu_awvalid | lsu_wvalid;
    assign lsu_any_req = lsu_wr_req | lsu_arvalid;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    logic last_q;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake flags: cleared in IDLE, set once per grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (s_arvalid && s_arready) begin
                ar_done_q <= 1'b1;
            end
            if (s_awvalid && s_awready) begin
                aw_done_q <= 1'b1;
            end
            if (s_wvalid && s_wready) begin
                w_done_q <= 1'b1;
            end
        end
    end

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // Last winner, updated when IDLE hands out a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= MST_IFU;
        end else if (state_q == ST_IDLE && state_d != ST_IDLE) begin
            last_q <= (state_d == ST_IFU_RD) ? MST_IFU : MST_LSU;
        end
    end
`endif

    // Next state and channel routing.
    always_comb begin
        state_d     = state_q;

        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = RESP_OKAY;
        ifu_rvalid  = 1'b0;

        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = RESP_OKAY;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = RESP_OKAY;
        lsu_bvalid  = 1'b0;

        s_araddr    = '0;
        s_arvalid   = 1'b0;
        s_rready    = 1'b0;
        s_awaddr    = '0;
        s_awvalid   = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wvalid    = 1'b0;
        s_bready    = 1'b0;

        case (state_q)
            ST_IDLE: begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
                // LSU wins unless the IFU also requests and the LSU won last.
                if (lsu_any_req && (!ifu_arvalid || last_q == MST_IFU)) begin
                    state_d = lsu_wr_req ? ST_LSU_WR : ST_LSU_RD;
                end else if (ifu_arvalid) begin
                    state_d = ST_IFU_RD;
                end
`else
                if (lsu_wr_req) begin
                    state_d = ST_LSU_WR;
                end else if (lsu_any_req) begin
                    state_d = ST_LSU_RD;
                end else if (ifu_arvalid) begin
                    state_d = ST_IFU_RD;
                end
`endif
            end

            ST_IFU_RD: begin
                s_araddr    = ifu_araddr;
                s_arvalid   = ifu_arvalid & ~ar_done_q;
                ifu_arready = s_arready & ~ar_done_q;
                ifu_rdata   = s_rdata;
                ifu_rresp   = s_rresp;
                ifu_rvalid  = s_rvalid;
                s_rready    = ifu_rready;
                if (s_rvalid && ifu_rready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_LSU_RD: begin
                s_araddr    = lsu_araddr;
                s_arvalid   = lsu_arvalid & ~ar_done_q;
                lsu_arready = s_arready & ~ar_done_q;
                lsu_rdata   = s_rdata;
                lsu_rresp   = s_rresp;
                lsu_rvalid  = s_rvalid;
                s_rready    = lsu_rready;
                if (s_rvalid && lsu_rready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_LSU_WR: begin
                // AW and W are independent; each closes on its own handshake.
                s_awaddr    = lsu_awaddr;
                s_awvalid   = lsu_awvalid & ~aw_done_q;
                lsu_awready = s_awready & ~aw_done_q;
                s_wdata     = lsu_wdata;
                s_wstrb     = lsu_wstrb;
                s_wvalid    = lsu_wvalid & ~w_done_q;
                lsu_wready  = s_wready & ~w_done_q;
                lsu_bresp   = s_bresp;
                lsu_bvalid  = s_bvalid;
                s_bready    = lsu_bready;
                if (s_bvalid && lsu_bready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Self-checking bench for axi_lite_arbiter: a behavioural memory slave, a
// scoreboard of expected master-side responses and one task per scenario.
module tb_axi_lite_arbiter;
    import axi_lite_arbiter_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] ifu_araddr;
    logic              ifu_arvalid, ifu_arready;
    logic [DATA_W-1:0] ifu_rdata;
    logic [1:0]        ifu_rresp;
    logic              ifu_rvalid, ifu_rready;
    logic [ADDR_W-1:0] lsu_araddr;
    logic              lsu_arvalid, lsu_arready;
    logic [DATA_W-1:0] lsu_rdata;
    logic [1:0]        lsu_rresp;
    logic              lsu_rvalid, lsu_rready;
    logic [ADDR_W-1:0] lsu_awaddr;
    logic              lsu_awvalid, lsu_awready;
    logic [DATA_W-1:0] lsu_wdata;
    logic [STRB_W-1:0] lsu_wstrb;
    logic              lsu_wvalid, lsu_wready;
    logic [1:0]        lsu_bresp;
    logic              lsu_bvalid, lsu_bready;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_arvalid, s_arready;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rvalid, s_rready;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_awvalid, s_awready;
    logic [DATA_W-1:0] s_wdata;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_wvalid, s_wready;
    logic [1:0]        s_bresp;
    logic              s_bvalid, s_bready;

    typedef struct packed {
        logic        mst;
        logic        is_wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   b_hs_cnt = 0;
    int   b_cyc = 0;
    int   ifu_ar_cyc = 0;

    // Slave model state and knobs.
    logic [1:0]        sl_rresp;
    logic [1:0]        sl_bresp;
    logic              aw_seen, w_seen;
    int                aw_cnt = 0;
    int                w_cnt = 0;
    logic [ADDR_W-1:0] cap_awaddr;
    logic [DATA_W-1:0] cap_wdata;
    logic [STRB_W-1:0] cap_wstrb;

    assign s_arready  = 1'b1;
    assign s_awready  = 1'b1;
    assign s_wready   = 1'b1;
    assign ifu_rready = 1'b1;
    assign lsu_rready = 1'b1;
    assign lsu_bready = 1'b1;

    axi_lite_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents seen by reads.
    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0F0F);
    endfunction

    // Slave: one-cycle read latency, B issued once both AW and W arrived.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= 2'b00;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            aw_seen  <= 1'b0;
            w_seen   <= 1'b0;
        end else begin
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1;
                s_rdata  <= slave_rd(s_araddr);
                s_rresp  <= sl_rresp;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
            if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end else if ((aw_seen || (s_awvalid && s_awready)) &&
                         (w_seen || (s_wvalid && s_wready))) begin
                s_bvalid <= 1'b1;
                s_bresp  <= sl_bresp;
                aw_seen  <= 1'b0;
                w_seen   <= 1'b0;
            end else begin
                if (s_awvalid && s_awready) aw_seen <= 1'b1;
                if (s_wvalid && s_wready)   w_seen  <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (s_awvalid && s_awready) begin
            aw_cnt     <= aw_cnt + 1;
            cap_awaddr <= s_awaddr;
        end
        if (s_wvalid && s_wready) begin
            w_cnt     <= w_cnt + 1;
            cap_wdata <= s_wdata;
            cap_wstrb <= s_wstrb;
        end
    end

    // Scoreboard: every master-side response handshake pops one expectation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (ifu_arvalid && ifu_arready) ifu_ar_cyc = cyc;
            if (ifu_rvalid && ifu_rready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_ifu_r unexpected response data=%h", ifu_rdata);
                end else begin
                    e = sb_q.pop_front();
                    if (e.mst !== MST_IFU || e.is_wr !== 1'b0 || ifu_rdata !== e.data || ifu_rresp !== e.resp) begin
                        errors++;
                        $display("FAIL sb_ifu_r got IFU R data=%h resp=%b, expected mst=%0d wr=%0d data=%h resp=%b",
                                 ifu_rdata, ifu_rresp, e.mst, e.is_wr, e.data, e.resp);
                    end
                end
            end
            if (lsu_rvalid && lsu_rready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_lsu_r unexpected response data=%h", lsu_rdata);
                end else begin
                    e = sb_q.pop_front();
                    if (e.mst !== MST_LSU || e.is_wr !== 1'b0 || lsu_rdata !== e.data || lsu_rresp !== e.resp) begin
                        errors++;
                        $display("FAIL sb_lsu_r got LSU R data=%h resp=%b, expected mst=%0d wr=%0d data=%h resp=%b",
                                 lsu_rdata, lsu_rresp, e.mst, e.is_wr, e.data, e.resp);
                    end
                end
            end
            if (lsu_bvalid && lsu_bready) begin
                checks++;
                b_hs_cnt++;
                b_cyc = cyc;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_lsu_b unexpected response resp=%b", lsu_bresp);
                end else begin
                    e = sb_q.pop_front();
                    if (e.mst !== MST_LSU || e.is_wr !== 1'b1 || lsu_bresp !== e.resp) begin
                        errors++;
                        $display("FAIL sb_lsu_b got LSU B resp=%b, expected mst=%0d wr=%0d resp=%b",
                                 lsu_bresp, e.mst, e.is_wr, e.resp);
                    end
                end
            end
        end
    endtask

    // ---------------- master drivers ----------------
    task automatic issue_ifu_rd(input logic [31:0] addr);
        bit hs;
        hs = 1'b0;
        @(posedge clk); #1;
        ifu_araddr  = addr;
        ifu_arvalid = 1'b1;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            if (ifu_arready) hs = 1'b1;
        end
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        ifu_araddr  = '0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL ifu_ar_timeout addr=%h arready never seen, required 1", addr);
        end
    endtask

    task automatic issue_lsu_rd(input logic [31:0] addr);
        bit hs;
        hs = 1'b0;
        @(posedge clk); #1;
        lsu_araddr  = addr;
        lsu_arvalid = 1'b1;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            if (lsu_arready) hs = 1'b1;
        end
        @(posedge clk); #1;
        lsu_arvalid = 1'b0;
        lsu_araddr  = '0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL lsu_ar_timeout addr=%h arready never seen, required 1", addr);
        end
    endtask

    task automatic drive_aw(input logic [31:0] addr, input int dly);
        bit hs;
        hs = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
        end
        lsu_awaddr  = addr;
        lsu_awvalid = 1'b1;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            if (lsu_awready) hs = 1'b1;
        end
        @(posedge clk); #1;
        lsu_awvalid = 1'b0;
        lsu_awaddr  = '0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL aw_timeout addr=%h awready never seen, required 1", addr);
        end
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        bit hs;
        hs = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
        end
        lsu_wdata  = data;
        lsu_wstrb  = strb;
        lsu_wvalid = 1'b1;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            if (lsu_wready) hs = 1'b1;
        end
        @(posedge clk); #1;
        lsu_wvalid = 1'b0;
        lsu_wdata  = '0;
        lsu_wstrb  = '0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL w_timeout data=%h wready never seen, required 1", data);
        end
    endtask

    // Wait for the scoreboard to empty, then confirm the arbiter is idle.
    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain %0d responses outstanding, required 0", name, sb_q.size());
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (dut.state_q !== ST_IDLE || s_rready !== 1'b0 || s_bready !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle state=%0d s_rready=%b s_bready=%b, required IDLE 0 0",
                     name, dut.state_q, s_rready, s_bready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [11:0] outs;
        rst         = 1'b0;
        ifu_araddr  = 32'h1000_0040;
        ifu_arvalid = 1'b1;
        repeat (3) @(negedge clk);
        outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                lsu_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
        checks++;
        if (outs !== 12'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b, required 000000000000", outs);
        end
        sb_q.push_back('{mst: MST_IFU, is_wr: 1'b0, data: slave_rd(32'h1000_0040), resp: RESP_OKAY});
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_arvalid !== 1'b0 || ifu_arready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_cycle s_arvalid=%b ifu_arready=%b, required 0 0", s_arvalid, ifu_arready);
        end
        @(negedge clk);
        checks++;
        if (s_arvalid !== 1'b1 || ifu_arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_grant s_arvalid=%b ifu_arready=%b, required 1 1", s_arvalid, ifu_arready);
        end
        checks++;
        if (s_araddr !== 32'h1000_0040) begin
            errors++;
            $display("FAIL reset_araddr got %h, required 10000040", s_araddr);
        end
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        ifu_araddr  = '0;
        drain("reset");
    endtask

    task automatic test_ifu_read();
        bit got_r, lsu_seen, drop;
        got_r = 1'b0;
        lsu_seen = 1'b0;
        sb_q.push_back('{mst: MST_IFU, is_wr: 1'b0, data: 32'hDEAD_BEEF, resp: RESP_OKAY});
        @(posedge clk); #1;
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        for (int i = 0; i < 30 && !got_r; i++) begin
            @(negedge clk);
            if (lsu_rvalid) lsu_seen = 1'b1;
            if (ifu_rvalid && ifu_rready) got_r = 1'b1;
            drop = ifu_arvalid && ifu_arready;
            @(posedge clk); #1;
            if (drop) begin
                ifu_arvalid = 1'b0;
                ifu_araddr  = '0;
            end
        end
        checks++;
        if (!got_r) begin
            errors++;
            $display("FAIL ifu_read_timeout R handshake not seen, required within 30 cycles");
        end
        checks++;
        if (lsu_seen) begin
            errors++;
            $display("FAIL ifu_read_lsu_rvalid got 1, required 0");
        end
        @(negedge clk);
        checks++;
        if (dut.state_q !== ST_IDLE || ifu_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL ifu_read_back_idle state=%0d ifu_rvalid=%b, required IDLE 0", dut.state_q, ifu_rvalid);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL ifu_read_sb %0d outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic test_contention();
        logic [31:0] ia[3];
        logic [31:0] la[3];
        for (int k = 0; k < 3; k++) begin
            ia[k] = 32'h0000_1000 + 32'(k * 4);
            la[k] = 32'h0000_2000 + 32'(k * 4);
        end
`ifdef AXI_ARB_ROUND_ROBIN_EN
        for (int k = 0; k < 3; k++) begin
            sb_q.push_back('{mst: MST_LSU, is_wr: 1'b0, data: slave_rd(la[k]), resp: RESP_OKAY});
            sb_q.push_back('{mst: MST_IFU, is_wr: 1'b0, data: slave_rd(ia[k]), resp: RESP_OKAY});
        end
`else
        for (int k = 0; k < 3; k++)
            sb_q.push_back('{mst: MST_LSU, is_wr: 1'b0, data: slave_rd(la[k]), resp: RESP_OKAY});
        for (int k = 0; k < 3; k++)
            sb_q.push_back('{mst: MST_IFU, is_wr: 1'b0, data: slave_rd(ia[k]), resp: RESP_OKAY});
`endif
        fork
            begin
                for (int k = 0; k < 3; k++) issue_ifu_rd(ia[k]);
            end
            begin
                for (int k = 0; k < 3; k++) issue_lsu_rd(la[k]);
            end
        join
        drain("contention");
    endtask

    task automatic test_write_w_first();
        int aw0, w0, b0;
        aw0 = aw_cnt;
        w0  = w_cnt;
        b0  = b_hs_cnt;
        sb_q.push_back('{mst: MST_LSU, is_wr: 1'b1, data: 32'h0, resp: RESP_OKAY});
        fork
            drive_w(32'h1234_5678, 4'b0011, 0);
            drive_aw(32'h0000_0100, 2);
        join
        drain("write_w_first");
        checks++;
        if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1) begin
            errors++;
            $display("FAIL write_hs_count aw=%0d w=%0d, required 1 1", aw_cnt - aw0, w_cnt - w0);
        end
        checks++;
        if (b_hs_cnt - b0 != 1) begin
            errors++;
            $display("FAIL write_b_count got %0d, required 1", b_hs_cnt - b0);
        end
        checks++;
        if (cap_wdata !== 32'h1234_5678 || cap_wstrb !== 4'b0011 || cap_awaddr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL write_payload wdata=%h wstrb=%b awaddr=%h, required 12345678 0011 00000100",
                     cap_wdata, cap_wstrb, cap_awaddr);
        end
    endtask

    task automatic test_resp_errors();
        sl_bresp = RESP_SLVERR;
        sl_rresp = RESP_DECERR;
        sb_q.push_back('{mst: MST_LSU, is_wr: 1'b1, data: 32'h0, resp: RESP_SLVERR});
        sb_q.push_back('{mst: MST_IFU, is_wr: 1'b0, data: slave_rd(32'h0000_0500), resp: RESP_DECERR});
        fork
            begin
                fork
                    drive_aw(32'h0000_0200, 0);
                    drive_w(32'hCAFE_F00D, 4'b1111, 0);
                join
            end
            begin
                @(posedge clk);
                issue_ifu_rd(32'h0000_0500);
            end
        join
        drain("resp_errors");
        checks++;
        if (ifu_ar_cyc <= b_cyc) begin
            errors++;
            $display("FAIL pending_ifu_order ifu AR cycle=%0d B cycle=%0d, required AR after B", ifu_ar_cyc, b_cyc);
        end
        sl_bresp = RESP_OKAY;
        sl_rresp = RESP_OKAY;
    endtask

    task automatic test_reset_mid_write();
        logic [11:0] outs;
        int aw0, w0;
        drive_aw(32'h0000_3000, 0);
        lsu_wdata   = 32'h0BAD_0BAD;
        lsu_wstrb   = 4'b1111;
        lsu_wvalid  = 1'b1;
        lsu_awaddr  = 32'h0000_3004;
        lsu_awvalid = 1'b1;
        #1;
        checks++;
        if (s_wvalid !== 1'b1 || s_awvalid !== 1'b0 || lsu_awready !== 1'b0) begin
            errors++;
            $display("FAIL midwr_flags s_wvalid=%b s_awvalid=%b lsu_awready=%b, required 1 0 0",
                     s_wvalid, s_awvalid, lsu_awready);
        end
        rst = 1'b0;
        #1;
        outs = {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, lsu_awready, lsu_wready,
                lsu_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};
        checks++;
        if (outs !== 12'b0 || dut.state_q !== ST_IDLE) begin
            errors++;
            $display("FAIL midwr_reset outs=%b state=%0d, required all 0 and IDLE", outs, dut.state_q);
        end
        lsu_awvalid = 1'b0;
        lsu_wvalid  = 1'b0;
        lsu_awaddr  = '0;
        lsu_wdata   = '0;
        lsu_wstrb   = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        aw0 = aw_cnt;
        w0  = w_cnt;
        sb_q.push_back('{mst: MST_LSU, is_wr: 1'b1, data: 32'h0, resp: RESP_OKAY});
        fork
            drive_aw(32'h0000_4000, 0);
            drive_w(32'h5555_AAAA, 4'b1100, 1);
        join
        drain("midwr_after");
        checks++;
        if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || cap_wdata !== 32'h5555_AAAA || cap_awaddr !== 32'h0000_4000) begin
            errors++;
            $display("FAIL midwr_new_write aw=%0d w=%0d wdata=%h awaddr=%h, required 1 1 5555aaaa 00004000",
                     aw_cnt - aw0, w_cnt - w0, cap_wdata, cap_awaddr);
        end
    endtask

    task automatic test_back_to_back();
        int gaps;
        gaps = 0;
        sb_q.push_back('{mst: MST_LSU, is_wr: 1'b0, data: slave_rd(32'h0000_6000), resp: RESP_OKAY});
        sb_q.push_back('{mst: MST_LSU, is_wr: 1'b0, data: slave_rd(32'h0000_6004), resp: RESP_OKAY});
        fork
            begin
                issue_lsu_rd(32'h0000_6000);
                issue_lsu_rd(32'h0000_6004);
            end
            begin
                bit prev_r;
                prev_r = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (prev_r) begin
                        gaps++;
                        checks++;
                        if (s_arvalid !== 1'b0 || lsu_arready !== 1'b0) begin
                            errors++;
                            $display("FAIL b2b_idle_gap s_arvalid=%b lsu_arready=%b, required 0 0", s_arvalid, lsu_arready);
                        end
                    end
                    prev_r = lsu_rvalid && lsu_rready;
                end
            end
        join
        checks++;
        if (gaps != 2) begin
            errors++;
            $display("FAIL b2b_r_count got %0d R handshakes, required 2", gaps);
        end
        drain("b2b");
    endtask

    initial begin
        rst         = 1'b0;
        ifu_araddr  = '0;
        ifu_arvalid = 1'b0;
        lsu_araddr  = '0;
        lsu_arvalid = 1'b0;
        lsu_awaddr  = '0;
        lsu_awvalid = 1'b0;
        lsu_wdata   = '0;
        lsu_wstrb   = '0;
        lsu_wvalid  = 1'b0;
        sl_rresp    = RESP_OKAY;
        sl_bresp    = RESP_OKAY;
        fork
            monitor();
        join_none
        test_reset();
        test_ifu_read();
        test_contention();
        test_write_w_first();
        test_resp_errors();
        test_reset_mid_write();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
